// File: rtl/ram_sdp_stream_reader_if.sv
// Bundles the command, RAM read-port and output-stream signals of ram_sdp_stream_reader.
//   start/start_addr/count : command strobe, first address, word count (0..DEPTH)
//   busy/done              : command status; done is a 1-cycle pulse
//   ram_rden/ram_read_addr : RAM read request (combinational from the reader)
//   ram_read_data          : RAM read data, valid the cycle after ram_rden
//   out_valid/out_ready    : output stream handshake
//   out_data/out_last      : output word and end-of-command marker
// modport slave is the reader side; modport master is the command/RAM/consumer side.
interface ram_sdp_stream_reader_if #(
  parameter int unsigned WORD_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 3
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] start_addr;
  logic [ADDR_WIDTH:0]   count;
  logic                  busy;
  logic                  done;
  logic                  ram_rden;
  logic [ADDR_WIDTH-1:0] ram_read_addr;
  logic [WORD_WIDTH-1:0] ram_read_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [WORD_WIDTH-1:0] out_data;
  logic                  out_last;

  modport slave (
    input  start, start_addr, count, ram_read_data, out_ready,
    output busy, done, ram_rden, ram_read_addr, out_valid, out_data, out_last
  );

  modport master (
    output start, start_addr, count, ram_read_data, out_ready,
    input  busy, done, ram_rden, ram_read_addr, out_valid, out_data, out_last
  );
endinterface

// File: rtl/ram_sdp_stream_reader.sv
// Read-side client for a simple dual-port RAM with 1-cycle registered read latency.
// A start command issues COUNT sequential reads (address wraps DEPTH-1 -> 0) and returns
// the words as a valid/ready stream through a 2-entry buffer.
// Ports:
//   clock   : single clock, posedge
//   reset_n : asynchronous active-low reset
//   bus     : ram_sdp_stream_reader_if.slave (command, RAM read port, output stream)
module ram_sdp_stream_reader #(
  parameter int unsigned WORD_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned DEPTH      = 8
) (
  input logic                          clock,
  input logic                          reset_n,
  ram_sdp_stream_reader_if.slave       bus
);

  typedef enum logic [1:0] {StIdle, StRun, StFlush} state_e;

  localparam logic [ADDR_WIDTH-1:0] AddrLast = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   RemOne   = (ADDR_WIDTH+1)'(1);

  state_e                         state_q, state_d;
  logic [ADDR_WIDTH-1:0]          addr_q, addr_d;
  logic [ADDR_WIDTH:0]            remaining_q, remaining_d;
  logic                           inflight_q, inflight_d;
  logic                           inflight_last_q, inflight_last_d;
  logic                           done_q, done_d;
  logic [1:0][WORD_WIDTH-1:0]     buf_data_q, buf_data_d;
  logic [1:0]                     buf_last_q, buf_last_d;
  logic                           head_q, head_d;
  logic [1:0]                     occ_q, occ_d;

  logic       pop;
  logic       issue;
  logic       tail;
  logic [1:0] fill;

  always_comb begin
    pop  = (occ_q != 2'd0) && bus.out_ready;
    // Buffer slots plus the read already in flight; never exceeds 2.
    fill = occ_q + {1'b0, inflight_q};
    issue = (state_q == StRun) && (remaining_q != '0) &&
            ((fill < 2'd2) || ((fill == 2'd2) && pop));
    // occ==2 only coincides with a capture when the head is popped the same edge.
    tail = head_q ^ occ_q[0];

    state_d         = state_q;
    addr_d          = addr_q;
    remaining_d     = remaining_q;
    inflight_d      = issue;
    inflight_last_d = issue && (remaining_q == RemOne);
    done_d          = 1'b0;
    buf_data_d      = buf_data_q;
    buf_last_d      = buf_last_q;
    head_d          = pop ? ~head_q : head_q;
    occ_d           = occ_q + {1'b0, inflight_q} - {1'b0, pop};

    if (inflight_q) begin
      buf_data_d[tail] = bus.ram_read_data;
      buf_last_d[tail] = inflight_last_q;
    end

    if (issue) begin
      addr_d      = (addr_q == AddrLast) ? '0 : addr_q + 1'b1;
      remaining_d = remaining_q - 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          addr_d      = bus.start_addr;
          remaining_d = bus.count;
          state_d     = (bus.count != '0) ? StRun : StFlush;
        end
      end
      StRun: begin
        if (issue && (remaining_q == RemOne)) state_d = StFlush;
      end
      StFlush: begin
        // Empty flush covers count==0, where nothing was ever issued.
        if ((pop && buf_last_q[head_q]) || ((occ_q == 2'd0) && !inflight_q)) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= StIdle;
      addr_q          <= '0;
      remaining_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      done_q          <= 1'b0;
      buf_data_q      <= '0;
      buf_last_q      <= '0;
      head_q          <= 1'b0;
      occ_q           <= 2'd0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      remaining_q     <= remaining_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      done_q          <= done_d;
      buf_data_q      <= buf_data_d;
      buf_last_q      <= buf_last_d;
      head_q          <= head_d;
      occ_q           <= occ_d;
    end
  end

  assign bus.busy          = (state_q != StIdle);
  assign bus.done          = done_q;
  assign bus.ram_rden      = issue;
  assign bus.ram_read_addr = addr_q;
  assign bus.out_valid     = (occ_q != 2'd0);
  assign bus.out_data      = buf_data_q[head_q];
  assign bus.out_last      = (occ_q != 2'd0) && buf_last_q[head_q];

endmodule

// File: tb/tb_ram_sdp_stream_reader.sv
module tb_ram_sdp_stream_reader;
  localparam int unsigned WW    = 8;
  localparam int unsigned AW    = 3;
  localparam int unsigned DEPTH = 8;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  ram_sdp_stream_reader_if #(.WORD_WIDTH(WW), .ADDR_WIDTH(AW)) bus ();

  ram_sdp_stream_reader #(.WORD_WIDTH(WW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // RAM with 1-cycle registered read
  logic [WW-1:0] mem [DEPTH];
  logic [WW-1:0] ram_rdata;
  always @(posedge clock) if (bus.ram_rden) ram_rdata <= mem[bus.ram_read_addr];
  assign bus.ram_read_data = ram_rdata;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: records observed activity at the falling edge
  int            rd_addr_q[$];
  logic [WW:0]   got_q[$];
  int            got_cyc_q[$];
  int            done_cyc_q[$];
  int            valid_cnt, first_valid_cyc, first_rden_cyc, hold_err, busy_done_err;
  logic          stall_prev;
  logic [WW:0]   stall_word;

  always @(negedge clock) begin
    if (reset_n) begin
      if (bus.ram_rden) begin
        if (first_rden_cyc < 0) first_rden_cyc = cyc;
        rd_addr_q.push_back(int'(bus.ram_read_addr));
      end
      if (bus.out_valid) begin
        valid_cnt++;
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
      end
      if (stall_prev && !(bus.out_valid && ({bus.out_last, bus.out_data} == stall_word)))
        hold_err++;
      if (bus.out_valid && bus.out_ready) begin
        got_q.push_back({bus.out_last, bus.out_data});
        got_cyc_q.push_back(cyc);
      end
      if (bus.done) begin
        done_cyc_q.push_back(cyc);
        if (bus.busy) busy_done_err++;
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      stall_word = {bus.out_last, bus.out_data};
    end else begin
      stall_prev = 1'b0;
    end
  end

  // Reference model: the k-th word of a command is RAM[(start+k) mod DEPTH], last on k==count-1
  function automatic int exp_addr(int sa, int i);
    return (sa + i) % int'(DEPTH);
  endfunction

  function automatic logic [WW:0] exp_word(int sa, int cnt, int i);
    return {(i == cnt - 1), mem[exp_addr(sa, i)]};
  endfunction

  task automatic clear_mon();
    rd_addr_q.delete();
    got_q.delete();
    got_cyc_q.delete();
    done_cyc_q.delete();
    valid_cnt = 0;
    first_valid_cyc = -1;
    first_rden_cyc = -1;
    hold_err = 0;
    busy_done_err = 0;
    stall_prev = 1'b0;
  endtask

  // Called at posedge+1; returns the cycle number of the sampling edge E0
  task automatic start_cmd(input int sa, input int cnt, output int e0);
    bus.start = 1'b1;
    bus.start_addr = AW'(sa);
    bus.count = (AW+1)'(cnt);
    @(posedge clock); #1;
    bus.start = 1'b0;
    e0 = cyc;
  endtask

  task automatic run_until_done(input int budget, input bit rand_rdy, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done_cyc_q.size() != 0) begin
        ok = 1'b1;
        break;
      end
      @(posedge clock); #1;
      if (rand_rdy) bus.out_ready = ($urandom_range(0, 1) == 1);
    end
    repeat (3) begin @(posedge clock); #1; end
  endtask

  task automatic test_reset();
    total++;
    if ({bus.busy, bus.done, bus.ram_rden, bus.ram_read_addr, bus.out_valid, bus.out_last,
         bus.out_data} !== '0)
      begin bad++; $display("FAIL reset_outputs: got %b want 0", {bus.busy, bus.done,
        bus.ram_rden, bus.ram_read_addr, bus.out_valid, bus.out_last, bus.out_data}); end
    @(negedge clock); reset_n = 1'b1;
    @(posedge clock); #1;
    total++;
    if ({bus.busy, bus.done, bus.out_valid, bus.ram_rden} !== 4'b0)
      begin bad++; $display("FAIL reset_release_idle: got %b want 0000",
        {bus.busy, bus.done, bus.out_valid, bus.ram_rden}); end
  endtask

  task automatic test_basic();
    int e0;
    bit ok;
    logic [WW:0] g;
    int a;
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = WW'(i + 16);
    bus.out_ready = 1'b1;
    clear_mon();
    start_cmd(4, 3, e0);
    run_until_done(40, 1'b0, ok);
    total++; if (!ok) begin bad++; $display("FAIL basic_timeout: got 0 want 1"); end
    total++;
    if (got_q.size() != 3) begin bad++; $display("FAIL basic_words: got %0d want 3", got_q.size()); end
    for (int i = 0; i < 3; i++) begin
      g = (i < got_q.size()) ? got_q[i] : 'x;
      a = (i < rd_addr_q.size()) ? rd_addr_q[i] : -1;
      total++;
      if (g !== exp_word(4, 3, i))
        begin bad++; $display("FAIL basic_word%0d: got %h want %h", i, g, exp_word(4, 3, i)); end
      total++;
      if (a != exp_addr(4, i))
        begin bad++; $display("FAIL basic_addr%0d: got %0d want %0d", i, a, exp_addr(4, i)); end
    end
    total++;
    if (first_rden_cyc != e0)
      begin bad++; $display("FAIL basic_rden_latency: got %0d want %0d", first_rden_cyc, e0); end
    total++;
    if (first_valid_cyc != e0 + 2)
      begin bad++; $display("FAIL basic_valid_latency: got %0d want %0d", first_valid_cyc, e0 + 2); end
    total++;
    if (got_cyc_q.size() != 3 || got_cyc_q[2] - got_cyc_q[0] != 2)
      begin bad++; $display("FAIL basic_back_to_back: got %0d words want 3 consecutive", got_cyc_q.size()); end
    total++;
    if (done_cyc_q.size() != 1 || done_cyc_q[0] != e0 + 5)
      begin bad++; $display("FAIL basic_done: got %0d pulses want 1 at %0d", done_cyc_q.size(), e0 + 5); end
    total++;
    if (busy_done_err != 0) begin bad++; $display("FAIL basic_busy_with_done: got %0d want 0", busy_done_err); end
  endtask

  task automatic test_wrap();
    int e0;
    bit ok;
    logic [WW:0] g;
    int a;
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = WW'($urandom);
    bus.out_ready = 1'b1;
    clear_mon();
    start_cmd(6, 4, e0);
    run_until_done(40, 1'b0, ok);
    total++; if (!ok) begin bad++; $display("FAIL wrap_timeout: got 0 want 1"); end
    total++;
    if (rd_addr_q.size() != 4) begin bad++; $display("FAIL wrap_reads: got %0d want 4", rd_addr_q.size()); end
    for (int i = 0; i < 4; i++) begin
      g = (i < got_q.size()) ? got_q[i] : 'x;
      a = (i < rd_addr_q.size()) ? rd_addr_q[i] : -1;
      total++;
      if (a != exp_addr(6, i))
        begin bad++; $display("FAIL wrap_addr%0d: got %0d want %0d", i, a, exp_addr(6, i)); end
      total++;
      if (g !== exp_word(6, 4, i))
        begin bad++; $display("FAIL wrap_word%0d: got %h want %h", i, g, exp_word(6, 4, i)); end
    end
  endtask

  task automatic test_backpressure();
    int e0;
    bit ok;
    logic [WW:0] g;
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = WW'($urandom);
    bus.out_ready = 1'b0;
    clear_mon();
    start_cmd(1, 5, e0);
    repeat (10) begin @(posedge clock); #1; end
    total++;
    if (rd_addr_q.size() != 2)
      begin bad++; $display("FAIL bp_reads_during_stall: got %0d want 2", rd_addr_q.size()); end
    total++;
    if (valid_cnt == 0 || got_q.size() != 0)
      begin bad++; $display("FAIL bp_valid_no_xfer: got valid=%0d xfers=%0d want >0/0", valid_cnt, got_q.size()); end
    bus.out_ready = 1'b1;
    run_until_done(60, 1'b0, ok);
    total++; if (!ok) begin bad++; $display("FAIL bp_timeout: got 0 want 1"); end
    total++;
    if (got_q.size() != 5) begin bad++; $display("FAIL bp_words: got %0d want 5", got_q.size()); end
    for (int i = 0; i < 5; i++) begin
      g = (i < got_q.size()) ? got_q[i] : 'x;
      total++;
      if (g !== exp_word(1, 5, i))
        begin bad++; $display("FAIL bp_word%0d: got %h want %h", i, g, exp_word(1, 5, i)); end
    end
    total++;
    if (hold_err != 0) begin bad++; $display("FAIL bp_hold: got %0d violations want 0", hold_err); end
    total++;
    if (done_cyc_q.size() != 1) begin bad++; $display("FAIL bp_done: got %0d want 1", done_cyc_q.size()); end
  endtask

  task automatic test_zero_count();
    int e0;
    bit ok;
    bus.out_ready = 1'b1;
    clear_mon();
    start_cmd(3, 0, e0);
    run_until_done(20, 1'b0, ok);
    total++; if (!ok) begin bad++; $display("FAIL zero_timeout: got 0 want 1"); end
    total++;
    if (rd_addr_q.size() != 0 || valid_cnt != 0)
      begin bad++; $display("FAIL zero_activity: got reads=%0d valid=%0d want 0/0", rd_addr_q.size(), valid_cnt); end
    total++;
    if (done_cyc_q.size() != 1 || done_cyc_q[0] != e0 + 1)
      begin bad++; $display("FAIL zero_done: got %0d pulses want 1 at %0d", done_cyc_q.size(), e0 + 1); end
  endtask

  task automatic test_start_while_busy();
    int e0;
    bit ok;
    logic [WW:0] g;
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = WW'($urandom);
    bus.out_ready = 1'b1;
    clear_mon();
    start_cmd(2, 4, e0);
    bus.start = 1'b1;
    bus.start_addr = AW'(5);
    bus.count = (AW+1)'(2);
    @(posedge clock); #1;
    bus.start = 1'b0;
    run_until_done(40, 1'b0, ok);
    total++; if (!ok) begin bad++; $display("FAIL busy_start_timeout: got 0 want 1"); end
    total++;
    if (rd_addr_q.size() != 4 || got_q.size() != 4)
      begin bad++; $display("FAIL busy_start_counts: got reads=%0d words=%0d want 4/4", rd_addr_q.size(), got_q.size()); end
    for (int i = 0; i < 4; i++) begin
      g = (i < got_q.size()) ? got_q[i] : 'x;
      total++;
      if (g !== exp_word(2, 4, i))
        begin bad++; $display("FAIL busy_start_word%0d: got %h want %h", i, g, exp_word(2, 4, i)); end
    end
    total++;
    if (done_cyc_q.size() != 1) begin bad++; $display("FAIL busy_start_done: got %0d want 1", done_cyc_q.size()); end
  endtask

  task automatic test_reset_mid();
    int e0;
    bit ok;
    logic rden_before;
    logic [WW:0] g;
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = WW'($urandom);
    bus.out_ready = 1'b1;
    clear_mon();
    start_cmd(0, 6, e0);
    @(posedge clock); #1;
    @(posedge clock); #1;
    rden_before = bus.ram_rden;
    reset_n = 1'b0;
    #1;
    total++;
    if (!rden_before) begin bad++; $display("FAIL rst_mid_inflight: got 0 want 1"); end
    total++;
    if ({bus.busy, bus.done, bus.ram_rden, bus.ram_read_addr, bus.out_valid, bus.out_last,
         bus.out_data} !== '0)
      begin bad++; $display("FAIL rst_mid_outputs: got %b want 0", {bus.busy, bus.done,
        bus.ram_rden, bus.ram_read_addr, bus.out_valid, bus.out_last, bus.out_data}); end
    @(posedge clock); #1;
    @(negedge clock); reset_n = 1'b1;
    @(posedge clock); #1;
    clear_mon();
    repeat (5) begin @(posedge clock); #1; end
    total++;
    if (valid_cnt != 0 || rd_addr_q.size() != 0 || done_cyc_q.size() != 0)
      begin bad++; $display("FAIL rst_mid_stale: got valid=%0d reads=%0d done=%0d want 0/0/0",
        valid_cnt, rd_addr_q.size(), done_cyc_q.size()); end
    clear_mon();
    start_cmd(3, 4, e0);
    run_until_done(40, 1'b0, ok);
    total++; if (!ok) begin bad++; $display("FAIL rst_mid_restart_timeout: got 0 want 1"); end
    total++;
    if (got_q.size() != 4) begin bad++; $display("FAIL rst_mid_restart_words: got %0d want 4", got_q.size()); end
    for (int i = 0; i < 4; i++) begin
      g = (i < got_q.size()) ? got_q[i] : 'x;
      total++;
      if (g !== exp_word(3, 4, i))
        begin bad++; $display("FAIL rst_mid_word%0d: got %h want %h", i, g, exp_word(3, 4, i)); end
    end
  endtask

  task automatic test_random();
    int e0, sa, cnt;
    bit ok;
    logic [WW:0] g;
    int a;
    for (int n = 0; n < 25; n++) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] = WW'($urandom);
      sa = int'($urandom_range(0, DEPTH - 1));
      cnt = int'($urandom_range(0, DEPTH));
      bus.out_ready = ($urandom_range(0, 1) == 1);
      clear_mon();
      start_cmd(sa, cnt, e0);
      run_until_done(300, 1'b1, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL rand%0d_timeout: got 0 want 1", n); end
      total++;
      if (got_q.size() != cnt || rd_addr_q.size() != cnt)
        begin bad++; $display("FAIL rand%0d_counts: got words=%0d reads=%0d want %0d", n,
          got_q.size(), rd_addr_q.size(), cnt); end
      for (int i = 0; i < cnt; i++) begin
        g = (i < got_q.size()) ? got_q[i] : 'x;
        a = (i < rd_addr_q.size()) ? rd_addr_q[i] : -1;
        total++;
        if (g !== exp_word(sa, cnt, i) || a != exp_addr(sa, i))
          begin bad++; $display("FAIL rand%0d_item%0d: got %h@%0d want %h@%0d", n, i, g, a,
            exp_word(sa, cnt, i), exp_addr(sa, i)); end
      end
      total++;
      if (hold_err != 0 || done_cyc_q.size() != 1 || busy_done_err != 0)
        begin bad++; $display("FAIL rand%0d_protocol: got hold=%0d done=%0d busydone=%0d want 0/1/0",
          n, hold_err, done_cyc_q.size(), busy_done_err); end
    end
    bus.out_ready = 1'b1;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.start_addr = '0;
    bus.count = '0;
    bus.out_ready = 1'b0;
    clear_mon();
    #12;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero_count();
    test_start_while_busy();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
